// File: rtl/callret_ctrl.sv
// Return-address stack sequencer: arbitrates CALL/RET (and optional IRQ entry),
// strobes the stack, redirects the PC and latches overflow/underflow faults.
// Optional feature macro: CALLRET_IRQ_EN enables interrupt entry handling.
module callret_ctrl #(
    parameter int          DEPTH      = 8,
    parameter int          LVL_W      = 4,
    parameter logic [31:0] IRQ_VECTOR = 32'h0000_0010
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             call_req,
    input  logic             ret_req,
    input  logic [31:0]      call_target,
    input  logic [31:0]      return_pc,
    input  logic [31:0]      cur_pc,
    input  logic             irq_req,
    output logic             irq_ack,
    output logic             stack_push,
    output logic             stack_pop,
    output logic [31:0]      stack_wdata,
    input  logic [31:0]      stack_rdata,
    output logic             pc_load,
    output logic [31:0]      pc_next,
    output logic             busy,
    output logic [LVL_W-1:0] depth,
    output logic             fault,
    output logic [1:0]       fault_code,
    input  logic             fault_clr
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        WAIT,
        LOAD,
        FAULT
    } state_t;

    localparam logic [1:0] CODE_OVERFLOW  = 2'b01;
    localparam logic [1:0] CODE_UNDERFLOW = 2'b10;

    state_t      state;
    logic [31:0] target;
    logic        irq_win;
    logic        full;
    logic        empty;

`ifdef CALLRET_IRQ_EN
    assign irq_win = irq_req;
`else
    logic unused_irq;
    assign irq_win    = 1'b0;
    assign unused_irq = &{1'b0, irq_req, cur_pc};
`endif

    assign full  = (depth == LVL_W'(DEPTH));
    assign empty = (depth == '0);

    // Redirect target is latched at accept so pc_next only changes alongside pc_load.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            target      <= '0;
            irq_ack     <= 1'b0;
            stack_push  <= 1'b0;
            stack_pop   <= 1'b0;
            stack_wdata <= '0;
            pc_load     <= 1'b0;
            pc_next     <= '0;
            busy        <= 1'b0;
            depth       <= '0;
            fault       <= 1'b0;
            fault_code  <= 2'b00;
        end else begin
            irq_ack    <= 1'b0;
            stack_push <= 1'b0;
            stack_pop  <= 1'b0;
            pc_load    <= 1'b0;
            case (state)
                IDLE: begin
                    if (irq_win) begin
                        busy <= 1'b1;
                        if (full) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            fault_code <= CODE_OVERFLOW;
                        end else begin
                            state       <= PUSH;
                            stack_push  <= 1'b1;
                            stack_wdata <= cur_pc;
                            target      <= IRQ_VECTOR;
                            irq_ack     <= 1'b1;
                            depth       <= depth + LVL_W'(1);
                        end
                    end else if (ret_req) begin
                        busy <= 1'b1;
                        if (empty) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            fault_code <= CODE_UNDERFLOW;
                        end else begin
                            state     <= POP;
                            stack_pop <= 1'b1;
                            depth     <= depth - LVL_W'(1);
                        end
                    end else if (call_req) begin
                        busy <= 1'b1;
                        if (full) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            fault_code <= CODE_OVERFLOW;
                        end else begin
                            state       <= PUSH;
                            stack_push  <= 1'b1;
                            stack_wdata <= return_pc;
                            target      <= call_target;
                            depth       <= depth + LVL_W'(1);
                        end
                    end
                end
                PUSH: begin
                    state   <= LOAD;
                    pc_load <= 1'b1;
                    pc_next <= target;
                end
                POP: begin
                    state <= WAIT;
                end
                // Stack output becomes valid the cycle after the pop strobe.
                WAIT: begin
                    state   <= LOAD;
                    pc_load <= 1'b1;
                    pc_next <= stack_rdata;
                end
                LOAD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                FAULT: begin
                    if (fault_clr) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        fault      <= 1'b0;
                        fault_code <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_callret_ctrl.sv
// Testbench for callret_ctrl: directed vector table, hand-written corner sequences
// and randomized operations checked against a transaction-level stack model.
module tb_callret_ctrl;

`ifdef CALLRET_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam int          DEPTH   = 8;
    localparam logic [31:0] NO_LOAD = 32'hDEAD_DEAD;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        call_req = 1'b0;
    logic        ret_req = 1'b0;
    logic [31:0] call_target = '0;
    logic [31:0] return_pc = '0;
    logic [31:0] cur_pc = '0;
    logic        irq_req = 1'b0;
    logic        irq_ack;
    logic        stack_push;
    logic        stack_pop;
    logic [31:0] stack_wdata;
    logic [31:0] stack_rdata;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        busy;
    logic [3:0]  depth;
    logic        fault;
    logic [1:0]  fault_code;
    logic        fault_clr = 1'b0;

    int passed = 0;
    int total  = 0;

    logic [31:0] ref_q[$];
    logic [31:0] stk[$];

    always #5 clock = ~clock;

    callret_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .call_req   (call_req),
        .ret_req    (ret_req),
        .call_target(call_target),
        .return_pc  (return_pc),
        .cur_pc     (cur_pc),
        .irq_req    (irq_req),
        .irq_ack    (irq_ack),
        .stack_push (stack_push),
        .stack_pop  (stack_pop),
        .stack_wdata(stack_wdata),
        .stack_rdata(stack_rdata),
        .pc_load    (pc_load),
        .pc_next    (pc_next),
        .busy       (busy),
        .depth      (depth),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_clr  (fault_clr)
    );

    // Behavioural stack instance fed by the DUT strobes; read data lags pop by one cycle.
    always @(posedge clock) begin
        if (!reset) begin
            stk.delete();
            stack_rdata <= '0;
        end else if (stack_push) begin
            stk.push_back(stack_wdata);
        end else if (stack_pop && stk.size() > 0) begin
            stack_rdata <= stk[$];
            stk.pop_back();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_cycle(input string tag, input bit e_push, input bit e_pop, input bit e_load,
                               input bit e_busy, input bit e_ack, input bit e_fault,
                               input logic [1:0] e_code, input int e_depth);
        check({tag, ".push"}, 32'(stack_push), 32'(e_push));
        check({tag, ".pop"}, 32'(stack_pop), 32'(e_pop));
        check({tag, ".pc_load"}, 32'(pc_load), 32'(e_load));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".irq_ack"}, 32'(irq_ack), 32'(e_ack));
        check({tag, ".fault"}, 32'(fault), 32'(e_fault));
        check({tag, ".code"}, 32'(fault_code), 32'(e_code));
        check({tag, ".depth"}, 32'(depth), 32'(e_depth));
    endtask

    // In FAULT every request is held high for a while and must be ignored until fault_clr.
    task automatic fault_seq(input logic [1:0] code, input int d);
        check_cycle("fault", 0, 0, 0, 1, 0, 1, code, d);
        call_req = 1'b1;
        ret_req  = 1'b1;
        irq_req  = 1'b1;
        repeat (2) begin
            tick();
            check_cycle("fault_hold", 0, 0, 0, 1, 0, 1, code, d);
        end
        call_req  = 1'b0;
        ret_req   = 1'b0;
        irq_req   = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check_cycle("fault_clr", 0, 0, 0, 0, 0, 0, 2'b00, d);
    endtask

    // One request issued from IDLE; the expected sequence follows from the model's stack contents.
    task automatic applyStimulus(input bit c, input bit r, input bit i,
                                 input logic [31:0] tgt, input logic [31:0] rpc, input logic [31:0] cpc,
                                 output logic [31:0] seen_pc, output logic [1:0] seen_code);
        int          d;
        bit          is_irq;
        bit          is_push;
        logic [31:0] exp_pc;
        d       = ref_q.size();
        is_irq  = IRQ_EN && i;
        is_push = is_irq || (!r && c);
        call_req    = c;
        ret_req     = r;
        irq_req     = i;
        call_target = tgt;
        return_pc   = rpc;
        cur_pc      = cpc;
        fault_clr   = 1'($urandom_range(0, 1));
        tick();
        call_req  = 1'b0;
        ret_req   = 1'b0;
        irq_req   = 1'b0;
        fault_clr = 1'b0;
        seen_pc   = NO_LOAD;
        seen_code = fault_code;
        if (is_push) begin
            if (d < DEPTH) begin
                check_cycle("push", 1, 0, 0, 1, is_irq, 0, 2'b00, d + 1);
                check("push.wdata", stack_wdata, is_irq ? cpc : rpc);
                ref_q.push_back(is_irq ? cpc : rpc);
                tick();
                check_cycle("call_load", 0, 0, 1, 1, 0, 0, 2'b00, d + 1);
                check("call_load.pc_next", pc_next, is_irq ? 32'h0000_0010 : tgt);
                if (pc_load) seen_pc = pc_next;
                tick();
                check_cycle("call_idle", 0, 0, 0, 0, 0, 0, 2'b00, d + 1);
            end else begin
                fault_seq(2'b01, d);
            end
        end else if (r) begin
            if (d > 0) begin
                exp_pc = ref_q[$];
                ref_q.pop_back();
                check_cycle("pop", 0, 1, 0, 1, 0, 0, 2'b00, d - 1);
                tick();
                check_cycle("wait", 0, 0, 0, 1, 0, 0, 2'b00, d - 1);
                tick();
                check_cycle("ret_load", 0, 0, 1, 1, 0, 0, 2'b00, d - 1);
                check("ret_load.pc_next", pc_next, exp_pc);
                if (pc_load) seen_pc = pc_next;
                tick();
                check_cycle("ret_idle", 0, 0, 0, 0, 0, 0, 2'b00, d - 1);
            end else begin
                fault_seq(2'b10, 0);
            end
        end else begin
            check_cycle("noop", 0, 0, 0, 0, 0, 0, 2'b00, d);
        end
    endtask

    typedef struct {
        bit          c;
        bit          r;
        bit          i;
        logic [31:0] tgt;
        logic [31:0] rpc;
        logic [31:0] cpc;
        logic [31:0] exp_pc;
        logic [1:0]  exp_code;
        int          exp_depth;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        vec_t        vecs[11];
        logic [31:0] seen_pc;
        logic [1:0]  seen_code;

        vecs[0]  = '{1, 0, 0, 32'h40,  32'h05, 32'h0,  32'h40,  2'b00, 1};
        vecs[1]  = '{0, 1, 0, 32'h0,   32'h0,  32'h0,  32'h05,  2'b00, 0};
        vecs[2]  = '{1, 0, 0, 32'h100, 32'h11, 32'h0,  32'h100, 2'b00, 1};
        vecs[3]  = '{1, 0, 0, 32'h200, 32'h22, 32'h0,  32'h200, 2'b00, 2};
        vecs[4]  = '{1, 1, 0, 32'h300, 32'h33, 32'h0,  32'h22,  2'b00, 1};
        vecs[5]  = '{0, 1, 0, 32'h0,   32'h0,  32'h0,  32'h11,  2'b00, 0};
        vecs[6]  = '{1, 0, 1, 32'h500, 32'h55, 32'h22, IRQ_EN ? 32'h10 : 32'h500, 2'b00, 1};
        vecs[7]  = '{1, 0, 0, 32'h600, 32'h66, 32'h0,  32'h600, 2'b00, 2};
        vecs[8]  = '{0, 1, 0, 32'h0,   32'h0,  32'h0,  32'h66,  2'b00, 1};
        vecs[9]  = '{0, 1, 0, 32'h0,   32'h0,  32'h0,  IRQ_EN ? 32'h22 : 32'h55, 2'b00, 0};
        vecs[10] = '{0, 1, 0, 32'h0,   32'h0,  32'h0,  NO_LOAD, 2'b10, 0};

        reset = 1'b0;
        tick();
        tick();
        check_cycle("reset", 0, 0, 0, 0, 0, 0, 2'b00, 0);
        checkOutput("reset.pc_next", pc_next, 32'h0);
        checkOutput("reset.wdata", stack_wdata, 32'h0);
        reset = 1'b1;
        tick();

        for (int k = 0; k < 11; k++) begin
            applyStimulus(vecs[k].c, vecs[k].r, vecs[k].i, vecs[k].tgt, vecs[k].rpc, vecs[k].cpc,
                          seen_pc, seen_code);
            checkOutput($sformatf("vec%0d.pc", k), seen_pc, vecs[k].exp_pc);
            checkOutput($sformatf("vec%0d.code", k), 32'(seen_code), 32'(vecs[k].exp_code));
            checkOutput($sformatf("vec%0d.depth", k), 32'(depth), 32'(vecs[k].exp_depth));
        end

        // Fill the stack, then a ninth CALL must fault without pushing or redirecting.
        for (int k = 0; k < DEPTH; k++)
            applyStimulus(1, 0, 0, $urandom, $urandom, $urandom, seen_pc, seen_code);
        checkOutput("full.depth", 32'(depth), 32'd8);
        applyStimulus(1, 0, 0, 32'h900, 32'h99, 32'h0, seen_pc, seen_code);
        checkOutput("overflow.code", 32'(seen_code), 32'd1);
        checkOutput("overflow.pc", seen_pc, NO_LOAD);
        checkOutput("overflow.depth", 32'(depth), 32'd8);
        applyStimulus(1, 0, 1, 32'h900, 32'h99, 32'h77, seen_pc, seen_code);
        checkOutput("overflow2.code", 32'(seen_code), 32'd1);
        applyStimulus(0, 1, 0, 32'h0, 32'h0, 32'h0, seen_pc, seen_code);
        checkOutput("after_full.depth", 32'(depth), 32'd7);

        // Reset in the middle of a RET abandons it.
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        check_cycle("mid_pop", 0, 1, 0, 1, 0, 0, 2'b00, 6);
        reset = 1'b0;
        tick();
        check_cycle("mid_reset", 0, 0, 0, 0, 0, 0, 2'b00, 0);
        reset = 1'b1;
        ref_q.delete();
        tick();

        for (int k = 0; k < 200; k++) begin
            bit rc;
            bit rr;
            bit ri;
            rc = ($urandom_range(0, 99) < 55);
            rr = ($urandom_range(0, 99) < 35);
            ri = ($urandom_range(0, 99) < 15);
            applyStimulus(rc, rr, ri, $urandom, $urandom, $urandom, seen_pc, seen_code);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
